// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: two-digit 7-segment refresh scanner.
//
// Alternates the units and tens digits of a two-digit display by driving
// the active-low enables En_unidad / En_decena. A short blanking gap with
// both digits dark separates the lit slots so the segment pattern of one
// digit never bleeds onto the other while the mux is switching.
//
// En_decena doubles as the select of the downstream units/tens segment
// mux (1 = pass the units pattern).
//
// Optional build macro:
//   DISPLAY_SCAN_CTRL_LZB_EN  leading-zero blanking. When defined, the tens
//                             digit is kept dark during its slot whenever
//                             tens_zero is 1. Slot timing, digit_sel and
//                             slot_tick are unaffected, so perceived
//                             brightness and scan period do not change.
//
// All outputs are registered and decoded from the next state, so they
// change on the same clock edge on which the FSM enters a state.

module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic disp_en,
  input  logic tens_zero,
  output logic En_unidad,
  output logic En_decena,
  output logic digit_sel,
  output logic slot_tick
);

  // Counter width covers the longest dwell, with a floor of 2 so that a
  // 1-bit counter exists even for the smallest legal configuration.
  localparam int MAX_DWELL = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_RANGE = (MAX_DWELL > 2) ? MAX_DWELL : 2;
  localparam int CNT_W     = $clog2(CNT_RANGE);

  // Terminal counts; a state is left when the counter reaches dwell-1.
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

  // When no blanking is requested the blank states are bypassed entirely.
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  localparam logic [1:0] BLANK_U = 2'd0;
  localparam logic [1:0] UNITS   = 2'd1;
  localparam logic [1:0] BLANK_T = 2'd2;
  localparam logic [1:0] TENS    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic lit_units_next;
  logic lit_tens_next;
  logic en_unidad_next;
  logic en_decena_next;
  logic digit_sel_next;
  logic slot_tick_next;

  // Next-state and dwell counter: the counter restarts at zero on every
  // state entry; a low disp_en parks the scan at the start of BLANK_U.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    if (!disp_en) begin
      state_next = BLANK_U;
      cnt_next   = '0;
    end else begin
      case (state)
        BLANK_U: begin
          if (NO_BLANK || (cnt == BLANK_LAST)) begin
            state_next = UNITS;
            cnt_next   = '0;
          end
        end
        UNITS: begin
          if (cnt == REFRESH_LAST) begin
            state_next = NO_BLANK ? TENS : BLANK_T;
            cnt_next   = '0;
          end
        end
        BLANK_T: begin
          if (NO_BLANK || (cnt == BLANK_LAST)) begin
            state_next = TENS;
            cnt_next   = '0;
          end
        end
        TENS: begin
          if (cnt == REFRESH_LAST) begin
            state_next = NO_BLANK ? UNITS : BLANK_U;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = BLANK_U;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state. Only one lit state can be entered
  // at a time, so the two enables can never both be low.
  always_comb begin
    lit_units_next = (state_next == UNITS);
    lit_tens_next  = (state_next == TENS);
    en_unidad_next = ~lit_units_next;
`ifdef DISPLAY_SCAN_CTRL_LZB_EN
    en_decena_next = ~lit_tens_next | tens_zero;
`else
    en_decena_next = ~lit_tens_next;
`endif
    digit_sel_next = digit_sel;
    if (lit_units_next) begin
      digit_sel_next = 1'b0;
    end else if (lit_tens_next) begin
      digit_sel_next = 1'b1;
    end
    slot_tick_next = (lit_units_next | lit_tens_next) & (cnt_next == REFRESH_LAST);
  end

`ifndef DISPLAY_SCAN_CTRL_LZB_EN
  // tens_zero only matters with leading-zero blanking built in.
  logic unused_tens_zero;
  assign unused_tens_zero = tens_zero;
`endif

  // State and dwell counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK_U;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Output registers, updated on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      En_unidad <= 1'b1;
      En_decena <= 1'b1;
      digit_sel <= 1'b0;
      slot_tick <= 1'b0;
    end else begin
      En_unidad <= en_unidad_next;
      En_decena <= en_decena_next;
      digit_sel <= digit_sel_next;
      slot_tick <= slot_tick_next;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl.
// Three instances with different timing parameters run side by side:
//   dut_a: REFRESH_DIV=4, BLANK_CYCLES=2 (also exercises disp_en)
//   dut_b: REFRESH_DIV=3, BLANK_CYCLES=0
//   dut_c: REFRESH_DIV=1, BLANK_CYCLES=1
// Expected outputs come from hand-written per-cycle pattern tables.

module tb_display_scan_ctrl;

  typedef struct packed {
    logic en_u;
    logic en_d;
    logic sel;
    logic tick;
  } exp_t;

`ifdef DISPLAY_SCAN_CTRL_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // dut_a, period 12: 2 blank, 4 units, 2 blank, 4 tens
  localparam logic [0:11] A_EU  = 12'b110000111111;
  localparam logic [0:11] A_ED  = 12'b111111110000;
  localparam logic [0:11] A_SEL = 12'b000000001111;
  localparam logic [0:11] A_TK  = 12'b000001000001;
  // dut_b, period 6 after the reset cycle: 3 units, 3 tens
  localparam logic [0:5]  B_EU  = 6'b000111;
  localparam logic [0:5]  B_ED  = 6'b111000;
  localparam logic [0:5]  B_SEL = 6'b000111;
  localparam logic [0:5]  B_TK  = 6'b001001;
  // dut_c, period 4 after the reset cycle: units, blank, tens, blank
  localparam logic [0:3]  C_EU  = 4'b0111;
  localparam logic [0:3]  C_ED  = 4'b1101;
  localparam logic [0:3]  C_SEL = 4'b0011;
  localparam logic [0:3]  C_TK  = 4'b1010;

  logic clk = 1'b0;
  logic rst_n;
  logic disp_en_a;
  logic disp_en_on;
  logic tens_zero;

  logic a_eu, a_ed, a_sel, a_tick;
  logic b_eu, b_ed, b_sel, b_tick;
  logic c_eu, c_ed, c_sel, c_tick;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en_a), .tens_zero(tens_zero),
    .En_unidad(a_eu), .En_decena(a_ed), .digit_sel(a_sel), .slot_tick(a_tick)
  );

  display_scan_ctrl #(.REFRESH_DIV(3), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en_on), .tens_zero(tens_zero),
    .En_unidad(b_eu), .En_decena(b_ed), .digit_sel(b_sel), .slot_tick(b_tick)
  );

  display_scan_ctrl #(.REFRESH_DIV(1), .BLANK_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en_on), .tens_zero(tens_zero),
    .En_unidad(c_eu), .En_decena(c_ed), .digit_sel(c_sel), .slot_tick(c_tick)
  );

  // Compare one observed output tuple against its expectation.
  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got eu=%b ed=%b sel=%b tick=%b, want eu=%b ed=%b sel=%b tick=%b",
               name, $time, act.en_u, act.en_d, act.sel, act.tick,
               exp.en_u, exp.en_d, exp.sel, exp.tick);
    end
  endtask

  // Both enables low at once would light both digits with one pattern.
  task automatic check_exclusive(input string name, input logic eu, input logic ed);
    vectors++;
    if (!(eu === 1'b1 || ed === 1'b1)) begin
      miscompares++;
      $display("[TB] FAIL %s_exclusive t=%0t: got eu=%b ed=%b, want not both 0", name, $time, eu, ed);
    end
  endtask

  // tens_zero is held high for cycles 24..35 of the first run.
  function automatic bit tz_run1(input int k);
    return (k >= 24) && (k <= 35);
  endfunction

  function automatic exp_t exp_a(input int k);
    exp_t e;
    int p;
    if (k == 46 || k == 47) begin
      e.en_u = 1'b1; e.en_d = 1'b1; e.sel = 1'b1; e.tick = 1'b0;
      return e;
    end
    p = (k < 46) ? (k % 12) : ((k - 48) % 12);
    e.en_u = A_EU[p];
    e.en_d = A_ED[p] | (LZB && tz_run1(k));
    e.sel  = (p < 2) ? (k >= 12) : A_SEL[p];
    e.tick = A_TK[p];
    return e;
  endfunction

  function automatic exp_t exp_b(input int k, input bit tz);
    exp_t e;
    int p;
    if (k == 0) begin
      e.en_u = 1'b1; e.en_d = 1'b1; e.sel = 1'b0; e.tick = 1'b0;
      return e;
    end
    p = (k - 1) % 6;
    e.en_u = B_EU[p];
    e.en_d = B_ED[p] | (LZB && tz);
    e.sel  = B_SEL[p];
    e.tick = B_TK[p];
    return e;
  endfunction

  function automatic exp_t exp_c(input int k, input bit tz);
    exp_t e;
    int p;
    if (k == 0) begin
      e.en_u = 1'b1; e.en_d = 1'b1; e.sel = 1'b0; e.tick = 1'b0;
      return e;
    end
    p = (k - 1) % 4;
    e.en_u = C_EU[p];
    e.en_d = C_ED[p] | (LZB && tz);
    e.sel  = C_SEL[p];
    e.tick = C_TK[p];
    return e;
  endfunction

  // Input changes for cycle k of the first run.
  task automatic apply_stimulus(input int k);
    if (k == 23) tens_zero = 1'b1;
    if (k == 35) tens_zero = 1'b0;
    if (k == 45) disp_en_a = 1'b0;
    if (k == 48) disp_en_a = 1'b1;
  endtask

  // Monitor: pops an expectation whenever one is pending and checks the
  // enable exclusivity of every instance on every cycle.
  always @(negedge clk) begin
    if (q_a.size() > 0) check_output("dut_a", {a_eu, a_ed, a_sel, a_tick}, q_a.pop_front());
    if (q_b.size() > 0) check_output("dut_b", {b_eu, b_ed, b_sel, b_tick}, q_b.pop_front());
    if (q_c.size() > 0) check_output("dut_c", {c_eu, c_ed, c_sel, c_tick}, q_c.pop_front());
    if (chk_on) begin
      check_exclusive("dut_a", a_eu, a_ed);
      check_exclusive("dut_b", b_eu, b_ed);
      check_exclusive("dut_c", c_eu, c_ed);
    end
  end

  // Stimulus: pushes the expected outputs of each cycle shortly after the
  // edge that starts it; the monitor samples mid-cycle.
  initial begin
    exp_t rst_exp;
    rst_exp.en_u = 1'b1; rst_exp.en_d = 1'b1; rst_exp.sel = 1'b0; rst_exp.tick = 1'b0;
    rst_n      = 1'b0;
    disp_en_a  = 1'b1;
    disp_en_on = 1'b1;
    tens_zero  = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int k = 0; k <= 53; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #2;
      end
      apply_stimulus(k);
      q_a.push_back(exp_a(k));
      q_b.push_back(exp_b(k, tz_run1(k)));
      q_c.push_back(exp_c(k, tz_run1(k)));
    end

    // Cycle 53 is the last units cycle of dut_a (slot_tick high); reset
    // lands between edges and must take effect without a clock.
    #4 rst_n = 1'b0;
    #1;
    check_output("async_rst_a", {a_eu, a_ed, a_sel, a_tick}, rst_exp);
    check_output("async_rst_b", {b_eu, b_ed, b_sel, b_tick}, rst_exp);
    check_output("async_rst_c", {c_eu, c_ed, c_sel, c_tick}, rst_exp);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #2;
      end
      q_b.push_back(exp_b(k, 1'b0));
      q_c.push_back(exp_c(k, 1'b0));
    end

    @(negedge clk);
    #1;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
